// File: rtl/rtc_bus_cycle_pkg.sv
// Shared definitions for the RTC multiplexed-bus cycle generator:
// FSM state codes, A/D select levels and default phase timings.
package rtc_bus_cycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_REQ_A = 4'd1,
        S_LAT_A = 4'd2,
        S_SU_A  = 4'd3,
        S_PW_A  = 4'd4,
        S_H_A   = 4'd5,
        S_REQ_D = 4'd6,
        S_LAT_D = 4'd7,
        S_SU_D  = 4'd8,
        S_PW_D  = 4'd9,
        S_H_D   = 4'd10,
        S_DONE  = 4'd11,
        S_GAP   = 4'd12
    } state_t;

    localparam logic AD_SEL_ADDR = 1'b0;
    localparam logic AD_SEL_DATA = 1'b1;

    localparam int T_SU_DEF  = 2;
    localparam int T_PW_DEF  = 8;
    localparam int T_H_DEF   = 2;
    localparam int T_GAP_DEF = 2;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rtc_bus_cycle_timer.sv
// Loadable down-counter shared by every timed bus phase; holds at zero
// instead of wrapping so a phase simply waits for the next load.
module rtc_bus_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Bus-cycle generator for the RTC multiplexed address/data bus: one address
// phase plus one data phase per write step, or a single-byte read.
//   IDLE        wait for en_write (armed) or en_read
//   REQ_A/LAT_A fetch address byte from sequencer      | REQ_D/LAT_D fetch data byte
//   SU/PW/H _A  address setup, strobe, hold            | SU/PW/H _D data setup, strobe, hold
//   DONE        step_done or rd_valid pulse            | GAP minimum idle, re-arm
module rtc_bus_cycle
    import rtc_bus_cycle_pkg::*;
#(
    parameter int T_SU  = T_SU_DEF,
    parameter int T_PW  = T_PW_DEF,
    parameter int T_H   = T_H_DEF,
    parameter int T_GAP = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_write,
    input  logic [7:0] wr_byte,
    output logic       dir_req,
    output logic       dat_req,
    output logic       step_done,
    input  logic       en_read,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n
);

    localparam int T_MAX = max4(T_SU, T_PW, T_H, T_GAP);
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] LD_SU  = CW'(T_SU - 1);
    localparam logic [CW-1:0] LD_PW  = CW'(T_PW - 1);
    localparam logic [CW-1:0] LD_H   = CW'(T_H - 1);
    localparam logic [CW-1:0] LD_GAP = CW'(T_GAP - 1);

    state_t        state_q, state_d;
    logic          is_write_q;
    logic          armed_q;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    rtc_bus_cycle_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (en_write && armed_q) begin
                    state_d = S_REQ_A;
                end else if (en_read) begin
                    state_d  = S_SU_A;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SU;
                end
            end
            S_REQ_A: state_d = S_LAT_A;
            S_LAT_A: begin
                state_d  = S_SU_A;
                tmr_load = 1'b1;
                tmr_val  = LD_SU;
            end
            S_SU_A: if (tmr_zero) begin
                state_d  = S_PW_A;
                tmr_load = 1'b1;
                tmr_val  = LD_PW;
            end
            S_PW_A: if (tmr_zero) begin
                state_d  = S_H_A;
                tmr_load = 1'b1;
                tmr_val  = LD_H;
            end
            S_H_A: if (tmr_zero) begin
                if (is_write_q) begin
                    state_d = S_REQ_D;
                end else begin
                    state_d  = S_SU_D;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SU;
                end
            end
            S_REQ_D: state_d = S_LAT_D;
            S_LAT_D: begin
                state_d  = S_SU_D;
                tmr_load = 1'b1;
                tmr_val  = LD_SU;
            end
            S_SU_D: if (tmr_zero) begin
                state_d  = S_PW_D;
                tmr_load = 1'b1;
                tmr_val  = LD_PW;
            end
            S_PW_D: if (tmr_zero) begin
                state_d  = S_H_D;
                tmr_load = 1'b1;
                tmr_val  = LD_H;
            end
            S_H_D: if (tmr_zero) state_d = S_DONE;
            S_DONE: begin
                state_d  = S_GAP;
                tmr_load = 1'b1;
                tmr_val  = LD_GAP;
            end
            S_GAP: if (tmr_zero) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            armed_q    <= 1'b1;
            ad_out     <= 8'h00;
            ad_oe      <= 1'b0;
            ad_sel     <= AD_SEL_DATA;
            rd_data    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && state_d == S_REQ_A) begin
                is_write_q <= 1'b1;
            end
            if (state_q == S_IDLE && state_d == S_SU_A) begin
                is_write_q <= 1'b0;
                ad_out     <= rd_addr;
                ad_oe      <= 1'b1;
                ad_sel     <= AD_SEL_ADDR;
            end
            if (state_q == S_LAT_A) begin
                ad_out <= wr_byte;
                ad_oe  <= 1'b1;
                ad_sel <= AD_SEL_ADDR;
            end
            // Read turns the bus around only after the address hold, strobes high.
            if (state_q == S_H_A && state_d == S_SU_D) begin
                ad_oe  <= 1'b0;
                ad_sel <= AD_SEL_DATA;
            end
            if (state_q == S_LAT_D) begin
                ad_out <= wr_byte;
                ad_sel <= AD_SEL_DATA;
            end
            if (state_q == S_PW_D && tmr_zero && !is_write_q) begin
                rd_data <= ad_in;
            end
            if (state_q == S_H_D && tmr_zero) begin
                ad_oe <= 1'b0;
            end
            // The sequencer drops E_esc a cycle late; stay disarmed until it does.
            if (state_q == S_DONE && is_write_q) begin
                armed_q <= 1'b0;
            end else if ((state_q == S_GAP || state_q == S_IDLE) && !en_write) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign dir_req   = (state_q == S_REQ_A);
    assign dat_req   = (state_q == S_REQ_D);
    assign step_done = (state_q == S_DONE) && is_write_q;
    assign rd_valid  = (state_q == S_DONE) && !is_write_q;
    assign busy      = (state_q != S_IDLE);
    assign cs_n      = !((state_q == S_PW_A) || (state_q == S_PW_D));
    assign wr_n      = !((state_q == S_PW_A) || ((state_q == S_PW_D) && is_write_q));
    assign rd_n      = !((state_q == S_PW_D) && !is_write_q);

endmodule
